// File: rtl/conv1x1_pkg.sv
// Shared constants, FSM state type and requantization for the 1x1 conv OFM writeback.
// Build option RELU_EN: clamps negative requantized lanes to zero inside requant().
package conv1x1_pkg;

    localparam int unsigned NUM_PE  = 4;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned GRP_W   = 9;
    localparam int unsigned CNT_W   = 24;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } wb_state_e;

    // Round-half-up arithmetic shift, then saturate to the output lane range.
    function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] psum,
                                                 input logic [SHIFT_W-1:0]      shift);
        logic signed [ACC_W:0] w_rnd;
        logic signed [ACC_W:0] w_sum;
        logic signed [ACC_W:0] w_shr;
        logic signed [ACC_W:0] w_max;
        logic signed [ACC_W:0] w_min;
        logic [OUT_W-1:0]      w_res;

        w_max = '0;
        w_max[OUT_W-2:0] = '1;
`ifdef RELU_EN
        w_min = '0;
`else
        w_min = '1;
        w_min[OUT_W-2:0] = '0;
`endif
        w_rnd = '0;
        if (shift != '0) begin
            w_rnd[shift - 1'b1] = 1'b1;
        end
        w_sum = {psum[ACC_W-1], psum} + w_rnd;
        w_shr = w_sum >>> shift;
        if (w_shr > w_max) begin
            w_res = w_max[OUT_W-1:0];
        end else if (w_shr < w_min) begin
            w_res = w_min[OUT_W-1:0];
        end else begin
            w_res = w_shr[OUT_W-1:0];
        end
        return w_res;
    endfunction

endpackage

// File: rtl/ofm_wr_fifo.sv
// Synchronous write-buffer FIFO; a push on a full FIFO is accepted only alongside a pop.
module ofm_wr_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [PTR_W:0]   o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/conv1x1_ofm_writeback.sv
// OFM writeback: captures per-PE psums, requantizes, buffers and writes words to OFM SRAM.
// Build option RELU_EN (see conv1x1_pkg) selects ReLU clamping of requantized lanes.
module conv1x1_ofm_writeback
    import conv1x1_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [7:0]              num_filter,
    input  logic [15:0]             num_pixel,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [SHIFT_W-1:0]      quant_shift,
    input  logic [NUM_PE-1:0]       PE_finish,
    input  logic [NUM_PE*ACC_W-1:0] pe_psum,
    output logic                    ofm_wr_en,
    output logic [ADDR_W-1:0]       ofm_wr_addr,
    output logic [NUM_PE*OUT_W-1:0] ofm_wr_data,
    input  logic                    ofm_wr_ready,
    output logic                    stall,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int unsigned DATA_W = NUM_PE * OUT_W;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_state_e          r_state;
    wb_state_e          w_state_nxt;
    logic [7:0]         r_nf;
    logic [GRP_W-1:0]   r_gpp;
    logic [CNT_W-1:0]   r_total;
    logic [ADDR_W-1:0]  r_base;
    logic [SHIFT_W-1:0] r_shift;
    logic [NUM_PE-1:0]  r_have;
    logic [ACC_W-1:0]   r_hold [NUM_PE];
    logic               r_push_pend;
    logic               r_err;
    logic               r_stall;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [GRP_W-1:0]   r_grp_cnt;

    logic               w_start_ok;
    logic [GRP_W-1:0]   w_gpp_in;
    logic [CNT_W-1:0]   w_total_in;
    logic               w_run;
    logic [NUM_PE-1:0]  w_have_eff;
    logic [NUM_PE-1:0]  w_finish;
    logic               w_have_all;
    logic               w_dbl;
    logic [DATA_W-1:0]  w_push_word;
    logic [DATA_W-1:0]  w_fifo_rdata;
    logic [FCNT_W-1:0]  w_fifo_count;
    logic [FCNT_W-1:0]  w_fifo_cnt_nxt;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_fifo_wr;
    logic               w_accept;
    logic               w_drop;
    logic               w_last_wr;

    assign w_start_ok = start && (r_state == IDLE);
    assign w_gpp_in   = (GRP_W'(num_filter) + GRP_W'(NUM_PE - 1)) / GRP_W'(NUM_PE);
    assign w_total_in = CNT_W'(num_pixel) * CNT_W'(w_gpp_in);
    assign w_run      = (r_state == RUN);

    // Bits still set on the push cycle belong to the group leaving now.
    assign w_have_eff = r_push_pend ? '0 : r_have;
    assign w_finish   = w_run ? PE_finish : '0;
    assign w_have_all = w_run && (&(w_have_eff | w_finish));
    assign w_dbl      = |(w_finish & w_have_eff);

    assign w_accept  = !w_fifo_empty && ofm_wr_ready;
    assign w_fifo_wr = r_push_pend && (!w_fifo_full || w_accept);
    assign w_drop    = r_push_pend && w_fifo_full && !w_accept;
    assign w_last_wr = w_accept && ((r_wr_cnt + 1'b1) == r_total);
    assign w_fifo_cnt_nxt = w_fifo_count + FCNT_W'(w_fifo_wr) - FCNT_W'(w_accept);

    always_comb begin
        w_push_word = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            w_push_word[i*OUT_W +: OUT_W] = requant(r_hold[i], r_shift);
        end
    end

    ofm_wr_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_push_pend),
        .i_wdata (w_push_word),
        .i_pop   (w_accept),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if ((r_total == '0) || w_last_wr) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (r_state == RUN) || (r_state == DONE);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nf        <= '0;
            r_gpp       <= '0;
            r_total     <= '0;
            r_base      <= '0;
            r_shift     <= '0;
            r_have      <= '0;
            r_hold      <= '{default: '0};
            r_push_pend <= 1'b0;
            r_err       <= 1'b0;
            r_stall     <= 1'b0;
            r_wr_cnt    <= '0;
            r_grp_cnt   <= '0;
        end else begin
            r_push_pend <= w_have_all;
            r_stall     <= (w_fifo_cnt_nxt >= FCNT_W'(FIFO_DEPTH - 2));
            for (int i = 0; i < NUM_PE; i++) begin
                if (w_finish[i]) begin
                    r_hold[i] <= pe_psum[i*ACC_W +: ACC_W];
                end
            end
            if (w_start_ok) begin
                r_nf      <= num_filter;
                r_gpp     <= w_gpp_in;
                r_total   <= w_total_in;
                r_base    <= base_addr;
                r_shift   <= quant_shift;
                r_have    <= '0;
                r_err     <= 1'b0;
                r_wr_cnt  <= '0;
                r_grp_cnt <= '0;
            end else begin
                r_have <= w_have_eff | w_finish;
                if (w_dbl || w_drop) begin
                    r_err <= 1'b1;
                end
                if (w_accept) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                    if ((r_grp_cnt + 1'b1) == r_gpp) begin
                        r_grp_cnt <= '0;
                    end else begin
                        r_grp_cnt <= r_grp_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign ofm_wr_en   = !w_fifo_empty;
    assign ofm_wr_addr = r_base + ADDR_W'(r_wr_cnt);
    assign stall       = r_stall;
    assign err         = r_err;

    // Lanes past num_filter in a pixel's last group carry no channel.
    always_comb begin
        ofm_wr_data = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (!w_fifo_empty &&
                ((16'(r_grp_cnt) * 16'(NUM_PE) + 16'(i)) < 16'(r_nf))) begin
                ofm_wr_data[i*OUT_W +: OUT_W] = w_fifo_rdata[i*OUT_W +: OUT_W];
            end
        end
    end

endmodule
